dlf_filter: RTL and testbench

Digital loop filter feeding the FLB stage. Sits between the TDC phase-error output and the FLB's `dlf_out`/`band` inputs, in the `ref_clk` domain. It runs a SAR coarse-band acquisition and then a proportional-integral tracking loop. It re-centres the integrator through automatic band slips and reports a lock indication.

---
 rtl/dlf_pkg.sv | 42 ++++
 rtl/dlf_band_sar.sv | 64 ++++++
 rtl/dlf_filter.sv | 140 ++++++++++++++
 tb/tb_dlf_filter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/dlf_pkg.sv
// dlf_pkg: shared types, constants and saturation helpers for dlf_filter.
// Holds the FSM state enum, mid-scale codes, slip threshold, sat_acc/sat_u16.
package dlf_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACQ   = 2'd1,
      ST_TRACK = 2'd2
   } dlf_state_e;

   localparam logic [15:0]        DLF_MID  = 16'h8000;
   localparam logic [7:0]         BAND_MID = 8'h80;
   localparam logic signed [63:0] SLIP_THR = 64'sh6000;

   // Symmetric clamp to +/-(2^(w-1)-1).
   function automatic logic signed [63:0] sat_acc(
      input logic signed [63:0] v,
      input int unsigned        w
   );
      logic signed [63:0] mx;
      mx = (64'sd1 <<< (w - 1)) - 64'sd1;
      if (v > mx)
         return mx;
      else if (v < -mx)
         return -mx;
      else
         return v;
   endfunction

   // Clamp to the unsigned 16-bit range [0, 65535].
   function automatic logic [15:0] sat_u16(
      input logic signed [63:0] v
   );
      if (v < 64'sd0)
         return 16'h0000;
      else if (v > 64'sd65535)
         return 16'hFFFF;
      else
         return v[15:0];
   endfunction

endpackage

// File: rtl/dlf_band_sar.sv
// dlf_band_sar: SAR coarse-band search, one band bit per ACQ_CNT valid samples.
// Ports: clk/rst, clr (restart at 8'h80), en (count a sample), err_in,
// band_d (trial band after this cycle), done (final SAR sample this cycle).
module dlf_band_sar #(
   parameter int ERR_W   = 10,
   parameter int ACQ_CNT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [ERR_W-1:0] err_in,
   output logic [7:0]       band_d,
   output logic             done
);
   import dlf_pkg::*;

   localparam int CW = (ACQ_CNT > 1) ? $clog2(ACQ_CNT) : 1;
   localparam logic [CW-1:0] LAST = CW'(ACQ_CNT - 1);
   localparam int AW = ERR_W + 5;

   logic [7:0]    band_q;
   logic [2:0]    bit_q;
   logic [CW-1:0] cnt_q;
   logic [AW-1:0] acc_q;
   logic [AW-1:0] acc_n;
   logic          step_end;

   always_comb begin
      acc_n    = acc_q + {{5{err_in[ERR_W-1]}}, err_in};
      band_d   = band_q;
      done     = 1'b0;
      step_end = en && (cnt_q == LAST);
      if (step_end) begin
         // Negative sum: the DCO is fast, so this band bit is too high.
         if (acc_n[AW-1])
            band_d[bit_q] = 1'b0;
         if (bit_q != 3'd0)
            band_d[bit_q - 3'd1] = 1'b1;
         else
            done = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         band_q <= BAND_MID;
         bit_q  <= 3'd7;
         cnt_q  <= '0;
         acc_q  <= '0;
      end else if (en) begin
         band_q <= band_d;
         if (step_end) begin
            bit_q <= bit_q - 3'd1;
            cnt_q <= '0;
            acc_q <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
            acc_q <= acc_n;
         end
      end
   end

endmodule

// File: rtl/dlf_filter.sv
// dlf_filter: digital loop filter, SAR band acquisition then PI tracking.
// Ports: ref_clk/rst, err_in/err_vld, loop_en, kp/ki shifts, lock_thr;
// outputs dlf_out, band, locked, state_o (all registered).
module dlf_filter #(
   parameter int          ERR_W     = 10,
   parameter int          ACC_W     = 24,
   parameter int          ACQ_CNT   = 16,
   parameter int          LOCK_CNT  = 64,
   parameter logic [15:0] BAND_STEP = 16'h4000
) (
   input  logic             ref_clk,
   input  logic             rst,
   input  logic [ERR_W-1:0] err_in,
   input  logic             err_vld,
   input  logic             loop_en,
   input  logic [3:0]       kp_shift,
   input  logic [3:0]       ki_shift,
   input  logic [ERR_W-2:0] lock_thr,
   output logic [15:0]      dlf_out,
   output logic [7:0]       band,
   output logic             locked,
   output logic [1:0]       state_o
);
   import dlf_pkg::*;

   localparam int LW = $clog2(LOCK_CNT + 1);

   dlf_state_e state_q, state_n;

   logic [ACC_W-1:0] integ_q;
   logic [LW-1:0]    lock_cnt_q;

   logic [7:0] sar_band_d;
   logic       sar_done;
   logic       sar_clr;
   logic       sar_en;

   logic [3:0] kp_c, ki_c;
   logic signed [63:0] e_w, integ_w, sum_w, sat_w;
   logic signed [63:0] slip_w, prop_w, out_w, mag_w, step_w;
   logic               up_slip, dn_slip, in_win;
   logic [ACC_W-1:0]   integ_nxt;
   logic [7:0]         band_nxt;
   logic [15:0]        dlf_nxt;
   logic [LW-1:0]      lock_cnt_nxt;
   logic               locked_nxt;

   assign sar_clr = !loop_en || (state_q != ST_ACQ);
   assign sar_en  = loop_en && (state_q == ST_ACQ) && err_vld;

   dlf_band_sar #(
      .ERR_W   (ERR_W),
      .ACQ_CNT (ACQ_CNT)
   ) u_sar (
      .clk    (ref_clk),
      .rst    (rst),
      .clr    (sar_clr),
      .en     (sar_en),
      .err_in (err_in),
      .band_d (sar_band_d),
      .done   (sar_done)
   );

   always_ff @(posedge ref_clk) begin
      if (rst)
         state_q <= ST_IDLE;
      else
         state_q <= state_n;
   end

   always_comb begin
      state_n = state_q;
      unique case (state_q)
         ST_IDLE:  state_n = ST_ACQ;
         ST_ACQ:   if (sar_done) state_n = ST_TRACK;
         ST_TRACK: state_n = ST_TRACK;
         default:  state_n = ST_IDLE;
      endcase
      if (!loop_en)
         state_n = ST_IDLE;
   end

   always_comb begin
      kp_c    = (kp_shift > 4'd12) ? 4'd12 : kp_shift;
      ki_c    = (ki_shift > 4'd12) ? 4'd12 : ki_shift;
      e_w     = {{(64-ERR_W){err_in[ERR_W-1]}}, err_in};
      integ_w = {{(64-ACC_W){integ_q[ACC_W-1]}}, integ_q};
      step_w  = {40'd0, BAND_STEP, 8'd0};
      sum_w   = integ_w + (e_w <<< ki_c);
      // Saturate first; the slip test then sees the clamped value.
      sat_w   = sat_acc(sum_w, ACC_W);
      up_slip = ((sat_w >>> 8) > SLIP_THR) && (band != 8'hFF);
      dn_slip = ((sat_w >>> 8) < -SLIP_THR) && (band != 8'h00);
      slip_w   = sat_w;
      band_nxt = band;
      if (up_slip) begin
         slip_w   = sat_w - step_w;
         band_nxt = band + 8'd1;
      end else if (dn_slip) begin
         slip_w   = sat_w + step_w;
         band_nxt = band - 8'd1;
      end
      integ_nxt = ACC_W'(slip_w);
      prop_w    = e_w <<< kp_c;
      out_w     = 64'sd32768 + ((slip_w + prop_w) >>> 8);
      dlf_nxt   = sat_u16(out_w);
      mag_w     = (e_w < 64'sd0) ? -e_w : e_w;
      in_win    = mag_w <= 64'(lock_thr);
      lock_cnt_nxt = lock_cnt_q;
      locked_nxt   = 1'b0;
      if (!in_win || up_slip || dn_slip) begin
         lock_cnt_nxt = '0;
      end else begin
         if (lock_cnt_q != LW'(LOCK_CNT))
            lock_cnt_nxt = lock_cnt_q + 1'b1;
         locked_nxt = (lock_cnt_nxt == LW'(LOCK_CNT));
      end
   end

   always_ff @(posedge ref_clk) begin
      if (rst || !loop_en) begin
         dlf_out    <= DLF_MID;
         band       <= BAND_MID;
         integ_q    <= '0;
         lock_cnt_q <= '0;
         locked     <= 1'b0;
      end else if (state_q == ST_ACQ) begin
         band <= sar_band_d;
      end else if (state_q == ST_TRACK && err_vld) begin
         dlf_out    <= dlf_nxt;
         band       <= band_nxt;
         integ_q    <= integ_nxt;
         lock_cnt_q <= lock_cnt_nxt;
         locked     <= locked_nxt;
      end
   end

   assign state_o = state_q;

endmodule

// File: tb/tb_dlf_filter.sv
// tb_dlf_filter: directed self-checking bench for dlf_filter.
// Drives #1 after each rising edge, checks #1 after the next.
module tb_dlf_filter;

   logic       ref_clk;
   logic       rst;
   logic [9:0] err_in;
   logic       err_vld;
   logic       loop_en;
   logic [3:0] kp_shift;
   logic [3:0] ki_shift;
   logic [8:0] lock_thr;
   logic [15:0] dlf_out;
   logic [7:0]  band;
   logic        locked;
   logic [1:0]  state_o;

   int checks = 0;
   int errors = 0;

   dlf_filter dut (
      .ref_clk  (ref_clk),
      .rst      (rst),
      .err_in   (err_in),
      .err_vld  (err_vld),
      .loop_en  (loop_en),
      .kp_shift (kp_shift),
      .ki_shift (ki_shift),
      .lock_thr (lock_thr),
      .dlf_out  (dlf_out),
      .band     (band),
      .locked   (locked),
      .state_o  (state_o)
   );

   initial ref_clk = 1'b0;
   always #5 ref_clk = ~ref_clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge ref_clk);
      #1;
   endtask

   task automatic smp(input int v);
      err_in  = 10'(v);
      err_vld = 1'b1;
      step();
      err_vld = 1'b0;
   endtask

   task automatic idle_chk(input string tag);
      check({tag, "_dlf"}, 32'(dlf_out), 32'h8000);
      check({tag, "_band"}, 32'(band), 32'h80);
      check({tag, "_lock"}, 32'(locked), 32'h0);
      check({tag, "_st"}, 32'(state_o), 32'h0);
   endtask

   initial begin
      rst = 1'b1; loop_en = 1'b0; err_in = '0; err_vld = 1'b0;
      kp_shift = 4'd8; ki_shift = 4'd0; lock_thr = 9'd0;
      repeat (3) step();
      idle_chk("rst");
      rst = 1'b0;
      for (int i = 0; i < 20; i++) smp(100);
      idle_chk("idle");

      // ACQ with +5: every bit kept.
      loop_en = 1'b1;
      step();
      check("acq_st", 32'(state_o), 32'h1);
      check("acq_b0", 32'(band), 32'h80);
      for (int i = 0; i < 16; i++) smp(5);
      check("acq_b16", 32'(band), 32'hC0);
      for (int i = 0; i < 111; i++) smp(5);
      check("acq_st127", 32'(state_o), 32'h1);
      smp(5);
      check("acq_pos_band", 32'(band), 32'hFF);
      check("acq_pos_st", 32'(state_o), 32'h2);
      check("acq_pos_dlf", 32'(dlf_out), 32'h8000);

      // Proportional path, then kp clamp, then hold without valid.
      smp(4);
      check("kp8_p4", 32'(dlf_out), 32'h8004);
      smp(0);
      check("kp8_z", 32'(dlf_out), 32'h8000);
      kp_shift = 4'd15;
      smp(1);
      check("kp_clamp", 32'(dlf_out), 32'h8010);
      err_in = 10'd100;
      repeat (5) step();
      check("hold_dlf", 32'(dlf_out), 32'h8010);
      check("hold_band", 32'(band), 32'hFF);
      loop_en = 1'b0;
      step();
      idle_chk("drop_trk");

      // ACQ with -5, then integrator saturation at band 0.
      kp_shift = 4'd0; ki_shift = 4'd12;
      loop_en = 1'b1;
      step();
      for (int i = 0; i < 16; i++) smp(-5);
      check("acq_neg_b16", 32'(band), 32'h40);
      for (int i = 0; i < 112; i++) smp(-5);
      check("acq_neg_band", 32'(band), 32'h00);
      check("acq_neg_st", 32'(state_o), 32'h2);
      smp(-512);
      check("neg_dlf1", 32'(dlf_out), 32'h5FFE);
      for (int i = 0; i < 3; i++) smp(-512);
      check("neg_sat_dlf", 32'(dlf_out), 32'h0000);
      check("neg_sat_band", 32'(band), 32'h00);

      // Mixed ACQ landing on 8'h80, then an up-slip.
      loop_en = 1'b0;
      step();
      loop_en = 1'b1;
      step();
      for (int i = 0; i < 16; i++) smp(5);
      check("mix_b16", 32'(band), 32'hC0);
      for (int i = 0; i < 112; i++) smp(-5);
      check("mix_band", 32'(band), 32'h80);
      check("mix_st", 32'(state_o), 32'h2);
      for (int i = 0; i < 3; i++) smp(511);
      check("slip3_dlf", 32'(dlf_out), 32'hDFD1);
      check("slip3_band", 32'(band), 32'h80);
      smp(511);
      check("slip4_band", 32'(band), 32'h81);
      check("slip4_dlf", 32'(dlf_out), 32'hBFC1);
      check("slip4_lock", 32'(locked), 32'h0);

      // Lock window.
      ki_shift = 4'd0; lock_thr = 9'd3;
      for (int i = 0; i < 63; i++) smp((i % 2 == 0) ? 2 : -2);
      check("lock63", 32'(locked), 32'h0);
      smp(2);
      check("lock64", 32'(locked), 32'h1);
      smp(4);
      check("unlock", 32'(locked), 32'h0);
      smp(-3);
      check("relock1", 32'(locked), 32'h0);

      // Drop loop_en mid-ACQ at k=4, then a clean restart.
      loop_en = 1'b0;
      step();
      loop_en = 1'b1;
      step();
      for (int i = 0; i < 53; i++) smp(5);
      check("mid_band", 32'(band), 32'hF0);
      check("mid_st", 32'(state_o), 32'h1);
      loop_en = 1'b0;
      step();
      idle_chk("mid_drop");
      loop_en = 1'b1;
      step();
      check("re_band", 32'(band), 32'h80);
      check("re_st", 32'(state_o), 32'h1);
      for (int i = 0; i < 127; i++) smp(-5);
      check("re_st127", 32'(state_o), 32'h1);
      smp(-5);
      check("re_band_end", 32'(band), 32'h00);
      check("re_st_end", 32'(state_o), 32'h2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
